// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory/run-control stage.
package cpu_mem_pkg;

    localparam int unsigned MEM_ADDR_WIDTH = 6;
    localparam int unsigned MEM_DEPTH      = 64;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// DEPTH x 8 resettable flop memory: one synchronous write port, one registered read port.
module mem_array #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DEPTH      = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [7:0]            wdata_i,
    input  logic                  re_i,
    input  logic                  rclr_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [7:0]            rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    // Storage: cleared on reset, one byte written per enabled edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register: captures on a read, zeroes on a write, otherwise holds.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (rclr_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_mem_ctrl.sv
// Memory and run-control stage: serves CPU stb/ack accesses in RUN, byte-stream loading in
// LOAD, and gates the core's execute enable so the two never overlap.
module cpu_mem_ctrl
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int unsigned DEPTH      = MEM_DEPTH,
    parameter bit          AUTO_RUN   = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  stb_i,
    output logic                  ack_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [7:0]            wdata_i,
    input  logic                  write_i,
    output logic [7:0]            rdata_o,
    output logic                  execute_o,
    input  logic                  load_start_i,
    input  logic                  load_valid_i,
    input  logic [7:0]            load_data_i,
    output logic                  load_ready_o,
    input  logic                  load_done_i,
    input  logic                  run_i,
    input  logic                  halt_i,
    output logic                  halted_o
);

    localparam logic [ADDR_WIDTH-1:0] PtrLast = ADDR_WIDTH'(DEPTH - 1);

    mem_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  busy_q, busy_d;
    logic                  halt_pend_q, halt_pend_d;

    logic                  in_run, in_load;
    logic                  halt_take, accept, load_we;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [7:0]            mem_wdata;

    assign in_run  = (state_q == RUN);
    assign in_load = (state_q == LOAD);

    // A pending halt is only taken once no access is in flight, and it blocks a new accept.
    assign halt_take = in_run && halt_pend_q && !busy_q;
    assign accept    = in_run && stb_i && !busy_q && !halt_take;
    assign load_we   = in_load && load_valid_i;

    // Next-state, load pointer, busy and halt-pending logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        busy_d      = accept;
        halt_pend_d = halt_pend_q;
        unique case (state_q)
            HALT: begin
                if (load_start_i) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                end else if (run_i) begin
                    state_d = RUN;
                end
            end
            LOAD: begin
                if (load_we) begin
                    ptr_d = ptr_q + 1'b1;
                end
                // Final byte or early done: a byte valid on the same edge is still stored.
                if ((load_we && (ptr_q == PtrLast)) || load_done_i) begin
                    state_d = AUTO_RUN ? RUN : HALT;
                    ptr_d   = '0;
                end
            end
            RUN: begin
                if (halt_take) begin
                    state_d     = HALT;
                    halt_pend_d = 1'b0;
                end else if (halt_i) begin
                    halt_pend_d = 1'b1;
                end
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= HALT;
            ptr_q       <= '0;
            busy_q      <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            busy_q      <= busy_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    // Write-port source select: the loader owns the port in LOAD, the CPU in RUN.
    assign mem_we    = load_we || (accept && write_i);
    assign mem_waddr = in_load ? ptr_q : addr_i;
    assign mem_wdata = in_load ? load_data_i : wdata_i;

    mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem_array (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .re_i    (accept && !write_i),
        .rclr_i  (accept && write_i),
        .raddr_i (addr_i),
        .rdata_o (rdata_o)
    );

    // Busy lasts exactly the cycle after accept, which is the ack cycle.
    assign ack_o        = busy_q;
    assign execute_o    = in_run;
    assign load_ready_o = in_load;
    assign halted_o     = (state_q == HALT);

endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// Self-checking bench for cpu_mem_ctrl: random load/access traffic against a memory model.
module tb_cpu_mem_ctrl;
    import cpu_mem_pkg::*;

    localparam int D = MEM_DEPTH;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       stb_i = 1'b0;
    logic       ack_o;
    logic [5:0] addr_i = '0;
    logic [7:0] wdata_i = '0;
    logic       write_i = 1'b0;
    logic [7:0] rdata_o;
    logic       execute_o;
    logic       load_start_i = 1'b0;
    logic       load_valid_i = 1'b0;
    logic [7:0] load_data_i = '0;
    logic       load_ready_o;
    logic       load_done_i = 1'b0;
    logic       run_i = 1'b0;
    logic       halt_i = 1'b0;
    logic       halted_o;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] model_mem [D];

    always #5 clk_i = ~clk_i;

    cpu_mem_ctrl dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .stb_i        (stb_i),
        .ack_o        (ack_o),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .write_i      (write_i),
        .rdata_o      (rdata_o),
        .execute_o    (execute_o),
        .load_start_i (load_start_i),
        .load_valid_i (load_valid_i),
        .load_data_i  (load_data_i),
        .load_ready_o (load_ready_o),
        .load_done_i  (load_done_i),
        .run_i        (run_i),
        .halt_i       (halt_i),
        .halted_o     (halted_o)
    );

    // Drive/sample point: 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_load();
        load_start_i = 1'b1;
        tick();
        load_start_i = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input logic done);
        load_valid_i = 1'b1;
        load_data_i  = b;
        load_done_i  = done;
        tick();
        load_valid_i = 1'b0;
        load_done_i  = 1'b0;
    endtask

    task automatic pulse_run();
        run_i = 1'b1;
        tick();
        run_i = 1'b0;
    endtask

    // halt_i sets the pending flag on one edge; with nothing in flight it is taken on the next.
    task automatic request_halt();
        halt_i = 1'b1;
        tick();
        halt_i = 1'b0;
        tick();
    endtask

    // One CPU access: samples the cycle after accept and the cycle after that.
    task automatic cpu_access(input logic wr, input logic [5:0] a, input logic [7:0] d,
                              output logic ack1, output logic [7:0] rd1, output logic ex1,
                              output logic ack2, output logic [7:0] rd2);
        stb_i   = 1'b1;
        write_i = wr;
        addr_i  = a;
        wdata_i = d;
        tick();
        stb_i   = 1'b0;
        write_i = 1'b0;
        ack1 = ack_o;
        rd1  = rdata_o;
        ex1  = execute_o;
        tick();
        ack2 = ack_o;
        rd2  = rdata_o;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        vectors++; if (halted_o !== 1'b1) begin miscompares++;
            $display("FAIL reset_halted: got %b want 1", halted_o); end
        vectors++; if (execute_o !== 1'b0) begin miscompares++;
            $display("FAIL reset_execute: got %b want 0", execute_o); end
        vectors++; if (ack_o !== 1'b0) begin miscompares++;
            $display("FAIL reset_ack: got %b want 0", ack_o); end
        vectors++; if (rdata_o !== 8'h00) begin miscompares++;
            $display("FAIL reset_rdata: got %h want 00", rdata_o); end
        vectors++; if (load_ready_o !== 1'b0) begin miscompares++;
            $display("FAIL reset_load_ready: got %b want 0", load_ready_o); end
        rst_ni = 1'b1;
        for (int i = 0; i < D; i++) model_mem[i] = 8'h00;
        tick();
        vectors++; if (halted_o !== 1'b1) begin miscompares++;
            $display("FAIL post_reset_halted: got %b want 1", halted_o); end
    endtask

    task automatic test_load_short();
        logic a1, e1, a2;
        logic [7:0] r1, r2;
        logic [7:0] bytes [3];
        bytes[0] = 8'h18; bytes[1] = 8'h2A; bytes[2] = 8'h00;
        start_load();
        vectors++; if (load_ready_o !== 1'b1 || halted_o !== 1'b0) begin miscompares++;
            $display("FAIL load_entry: got ready=%b halted=%b want 1/0", load_ready_o, halted_o); end
        // CPU strobe during LOAD must be ignored
        stb_i = 1'b1;
        tick();
        stb_i = 1'b0;
        vectors++; if (ack_o !== 1'b0) begin miscompares++;
            $display("FAIL stb_in_load: got ack=%b want 0", ack_o); end
        for (int i = 0; i < 3; i++) begin
            push_byte(bytes[i], i == 2);
            model_mem[i] = bytes[i];
        end
        vectors++; if (halted_o !== 1'b1 || execute_o !== 1'b0 || load_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL load_done_exit: got halted=%b exec=%b ready=%b want 1/0/0",
                     halted_o, execute_o, load_ready_o); end
        pulse_run();
        for (int i = 0; i < 3; i++) begin
            cpu_access(1'b0, 6'(i), 8'h00, a1, r1, e1, a2, r2);
            vectors++; if (a1 !== 1'b1 || r1 !== bytes[i]) begin miscompares++;
                $display("FAIL short_load_read[%0d]: got ack=%b data=%h want 1/%h",
                         i, a1, r1, bytes[i]); end
        end
        request_halt();
        vectors++; if (halted_o !== 1'b1) begin miscompares++;
            $display("FAIL halt_after_short: got %b want 1", halted_o); end
    endtask

    task automatic test_load_full();
        logic [7:0] b;
        start_load();
        for (int i = 0; i < D; i++) begin
            b = (i == 2) ? 8'h55 : 8'($urandom_range(255));
            model_mem[i] = b;
            if (i == D - 1) begin
                vectors++; if (load_ready_o !== 1'b1) begin miscompares++;
                    $display("FAIL full_ready_last: got %b want 1", load_ready_o); end
            end
            push_byte(b, 1'b0);
        end
        vectors++; if (halted_o !== 1'b1 || load_ready_o !== 1'b0) begin miscompares++;
            $display("FAIL full_exit: got halted=%b ready=%b want 1/0", halted_o, load_ready_o); end
        // 65th byte arrives in HALT and must not land anywhere
        push_byte(~model_mem[0], 1'b0);
        vectors++; if (halted_o !== 1'b1) begin miscompares++;
            $display("FAIL byte65_state: got halted=%b want 1", halted_o); end
    endtask

    task automatic test_run_read();
        logic a1, e1, a2;
        logic [7:0] r1, r2;
        logic [5:0] addrs [3];
        addrs[0] = 6'd2; addrs[1] = 6'd63; addrs[2] = 6'd0;
        pulse_run();
        vectors++; if (execute_o !== 1'b1 || halted_o !== 1'b0) begin miscompares++;
            $display("FAIL run_entry: got exec=%b halted=%b want 1/0", execute_o, halted_o); end
        for (int i = 0; i < 3; i++) begin
            cpu_access(1'b0, addrs[i], 8'h00, a1, r1, e1, a2, r2);
            vectors++; if (a1 !== 1'b1 || e1 !== 1'b1 || r1 !== model_mem[addrs[i]]) begin
                miscompares++;
                $display("FAIL run_read[%0d]: got ack=%b exec=%b data=%h want 1/1/%h",
                         addrs[i], a1, e1, r1, model_mem[addrs[i]]); end
            vectors++; if (a2 !== 1'b0 || r2 !== model_mem[addrs[i]]) begin miscompares++;
                $display("FAIL run_read_after[%0d]: got ack=%b data=%h want 0/%h",
                         addrs[i], a2, r2, model_mem[addrs[i]]); end
        end
    endtask

    task automatic test_write_read();
        logic a1, e1, a2, wr;
        logic [7:0] r1, r2, d, exp;
        logic [5:0] a;
        cpu_access(1'b1, 6'd10, 8'hA5, a1, r1, e1, a2, r2);
        model_mem[10] = 8'hA5;
        vectors++; if (a1 !== 1'b1 || r1 !== 8'h00 || a2 !== 1'b0) begin miscompares++;
            $display("FAIL write10: got ack=%b data=%h ack_next=%b want 1/00/0", a1, r1, a2); end
        cpu_access(1'b0, 6'd10, 8'h00, a1, r1, e1, a2, r2);
        vectors++; if (a1 !== 1'b1 || r1 !== 8'hA5) begin miscompares++;
            $display("FAIL read10: got ack=%b data=%h want 1/a5", a1, r1); end
        for (int n = 0; n < 24; n++) begin
            wr = 1'($urandom_range(1));
            a  = 6'($urandom_range(D - 1));
            d  = 8'($urandom_range(255));
            if (wr) begin
                model_mem[a] = d;
                exp = 8'h00;
            end else begin
                exp = model_mem[a];
            end
            cpu_access(wr, a, d, a1, r1, e1, a2, r2);
            vectors++; if (a1 !== 1'b1 || r1 !== exp || a2 !== 1'b0 || r2 !== exp) begin
                miscompares++;
                $display("FAIL rand_access[%0d] wr=%b a=%0d: got ack=%b/%b data=%h/%h want 1/0 %h",
                         n, wr, a, a1, a2, r1, r2, exp); end
        end
    endtask

    task automatic test_back_to_back();
        logic a1, e1, a2;
        logic [7:0] r1, r2;
        logic [5:0] a, b;
        a = 6'd20;
        b = 6'd21;
        stb_i = 1'b1; write_i = 1'b0; addr_i = a;
        tick();
        vectors++; if (ack_o !== 1'b1 || rdata_o !== model_mem[a]) begin miscompares++;
            $display("FAIL b2b_first: got ack=%b data=%h want 1/%h", ack_o, rdata_o, model_mem[a]); end
        // Strobe during the ack cycle: busy, so this write must be dropped.
        write_i = 1'b1; addr_i = b; wdata_i = ~model_mem[b];
        tick();
        stb_i = 1'b0; write_i = 1'b0;
        vectors++; if (ack_o !== 1'b0) begin miscompares++;
            $display("FAIL b2b_busy_ignored: got ack=%b want 0", ack_o); end
        tick();
        cpu_access(1'b0, b, 8'h00, a1, r1, e1, a2, r2);
        vectors++; if (a1 !== 1'b1 || r1 !== model_mem[b]) begin miscompares++;
            $display("FAIL b2b_no_write: got ack=%b data=%h want 1/%h", a1, r1, model_mem[b]); end
    endtask

    task automatic test_halt();
        logic [5:0] r, r2;
        logic seen;
        r  = 6'($urandom_range(D - 1));
        r2 = 6'($urandom_range(D - 1));
        stb_i = 1'b1; write_i = 1'b0; addr_i = r; halt_i = 1'b1;
        tick();
        halt_i = 1'b0;
        vectors++; if (ack_o !== 1'b1 || execute_o !== 1'b1 || rdata_o !== model_mem[r]) begin
            miscompares++;
            $display("FAIL halt_inflight_ack: got ack=%b exec=%b data=%h want 1/1/%h",
                     ack_o, execute_o, rdata_o, model_mem[r]); end
        // Core strobe for the next access stays high through the halt.
        addr_i = r2;
        tick();
        vectors++; if (ack_o !== 1'b0) begin miscompares++;
            $display("FAIL halt_ack_once: got ack=%b want 0", ack_o); end
        tick();
        vectors++; if (halted_o !== 1'b1 || execute_o !== 1'b0 || ack_o !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_taken: got halted=%b exec=%b ack=%b want 1/0/0",
                     halted_o, execute_o, ack_o); end
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ack_o !== 1'b0) seen = 1'b1;
        end
        vectors++; if (seen !== 1'b0) begin miscompares++;
            $display("FAIL stb_in_halt: got ack seen=%b want 0", seen); end
        run_i = 1'b1;
        tick();
        run_i = 1'b0;
        vectors++; if (execute_o !== 1'b1 || ack_o !== 1'b0) begin miscompares++;
            $display("FAIL resume_entry: got exec=%b ack=%b want 1/0", execute_o, ack_o); end
        tick();
        stb_i = 1'b0;
        vectors++; if (ack_o !== 1'b1 || rdata_o !== model_mem[r2]) begin miscompares++;
            $display("FAIL held_stb_ack: got ack=%b data=%h want 1/%h",
                     ack_o, rdata_o, model_mem[r2]); end
        tick();
        // halt_i and run_i together while running: halt wins
        halt_i = 1'b1; run_i = 1'b1;
        tick();
        halt_i = 1'b0; run_i = 1'b0;
        tick();
        vectors++; if (halted_o !== 1'b1) begin miscompares++;
            $display("FAIL halt_vs_run: got halted=%b want 1", halted_o); end
    endtask

    task automatic test_reset_mid();
        logic a1, e1, a2, seen;
        logic [7:0] r1, r2;
        pulse_run();
        cpu_access(1'b1, 6'd5, 8'h3C, a1, r1, e1, a2, r2);
        model_mem[5] = 8'h3C;
        stb_i = 1'b1; write_i = 1'b0; addr_i = 6'd5;
        tick();
        stb_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        vectors++; if (ack_o !== 1'b0 || execute_o !== 1'b0 || halted_o !== 1'b1 ||
                       rdata_o !== 8'h00 || load_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got ack=%b exec=%b halted=%b data=%h ready=%b want 0/0/1/00/0",
                     ack_o, execute_o, halted_o, rdata_o, load_ready_o); end
        for (int i = 0; i < D; i++) model_mem[i] = 8'h00;
        #5;
        rst_ni = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ack_o !== 1'b0) seen = 1'b1;
        end
        vectors++; if (seen !== 1'b0 || halted_o !== 1'b1) begin miscompares++;
            $display("FAIL post_abort: got ack seen=%b halted=%b want 0/1", seen, halted_o); end
        pulse_run();
        for (int i = 0; i < 4; i++) begin
            logic [5:0] a;
            a = (i == 0) ? 6'd5 : 6'($urandom_range(D - 1));
            cpu_access(1'b0, a, 8'h00, a1, r1, e1, a2, r2);
            vectors++; if (a1 !== 1'b1 || r1 !== model_mem[a]) begin miscompares++;
                $display("FAIL cleared_mem[%0d]: got ack=%b data=%h want 1/%h",
                         a, a1, r1, model_mem[a]); end
        end
    endtask

    initial begin
        test_reset();
        test_load_short();
        test_load_full();
        test_run_read();
        test_write_read();
        test_back_to_back();
        test_halt();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
